hamming_rx_ctrl: RTL
====================

# hamming_rx_ctrl

Receive-side frame controller for the Hamming-coded serial link. It detects start bits on the raw serial line, samples N code bits at mid-bit, and checks the stop bit. It then sequences the external syndrome decoder and corrector stages and presents corrected K-bit data on a valid/ready output with one-deep buffering. The block sits between the board serial input pin and the decryption stage, and replaces the free-running shift/count front end.

## Interface
- N, 7: code word length in bits (7, 9, 11 or 12)
- K, 4: data bits per code word
- C, 3: syndrome width
- CLKS_PER_BIT, 16: clk cycles per serial bit; even, ≥4

- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- rx_in  in  1  raw serial line, idle high, asynchronous to clk
- code_word  out  N  assembled code word, bit 0 = first received, to decoder
- code_valid  out  1  one-cycle strobe, code_word stable and decode results due this cycle
- syn_in  in  C  syndrome from decoder (combinational from code_word)
- corr_in  in  K  corrected data from syndrome corrector (combinational)
- data_out  out  K  buffered corrected data
- data_valid  out  1  data_out holds an unconsumed word
- data_ready  in  1  consumer accepts when data_valid && data_ready
- corr_flag  out  1  syndrome of the buffered word was nonzero; qualified by data_valid
- frame_err  out  1  one-cycle pulse, stop bit sampled low
- overrun  out  1  sticky; a frame arrived while the buffer was full
- busy  out  1  FSM not in IDLE
- err_count  out  8  corrected-frame count (see Configuration)

## Operation
- rx_in passes through a 2-flop synchronizer, giving rx_s. All line decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, DECODE.
- IDLE: on rx_s == 0, go to START and clear the bit-timer.
- START: at timer == CLKS_PER_BIT/2 − 1, sample rx_s.
  - If 1, it is a glitch: return to IDLE with no outputs.
  - If 0, go to DATA with the timer cleared and bit index 0.
- DATA: at timer == CLKS_PER_BIT − 1, sample rx_s into code_word[index], index++.
  - After index N−1 is sampled, go to STOP.
  - The timer wraps to 0 on every sample.
- STOP: at timer == CLKS_PER_BIT − 1, sample rx_s.
  - If 1, go to DECODE.
  - If 0, pulse frame_err, drop the frame, and go to IDLE.
- DECODE, one cycle: assert code_valid.
  - If the buffer is empty, or is being consumed this cycle: load data_out ← corr_in and corr_flag ← (syn_in != 0), and set data_valid.
  - Otherwise set overrun, drop the frame, and leave the buffer unchanged.
  - Go to IDLE.
- Buffer handshake: data_valid clears on the cycle after accept, unless DECODE reloads the buffer in that same cycle.
- code_word holds its value until the next DATA sample. Sampling is LSB first.
- Reset values: all outputs are 0 except code_word, which is also 0. FSM is IDLE, timer and index are 0, overrun is cleared. Reset mid-frame abandons the frame with no strobes.
- overrun clears only on rst.

## Timing
- Synchronizer latency: 2 cycles from an rx_in edge to rx_s.
- Start bit: the START sample falls at CLKS_PER_BIT/2 cycles after rx_s falls.
- Data sampling: each data sample is CLKS_PER_BIT cycles after the previous sample, so all samples land mid-bit.
- DECODE occupies the cycle after the STOP sample. data_valid rises the following cycle, giving a 2-cycle latency from stop sample to data_valid.
- Back-to-back frames: a new start bit is accepted from the cycle after DECODE. The minimum idle between frames is therefore the stop bit alone.
- Decode path: syn_in and corr_in must settle within the DECODE cycle. They are never registered inside the decoder path.

## Configuration
- HAMMING_RX_ERRCNT_EN defined: err_count is an 8-bit saturating counter.
  - Increments on each DECODE cycle where syn_in != 0 and the word is loaded into the buffer.
  - Holds at 8'hFF once it saturates.
  - Resets to 0.
- Not defined: err_count is tied to 8'h00 and no counter is synthesised.

## Test plan
The bench uses N=7, K=4, C=3, CLKS_PER_BIT=16, with the team's (7,4) decoder and corrector attached.
- Clean frame: send 7'b1011010, stop bit 1, data_ready = 1 → data_out = 4'b1011, corr_flag = 0, data_valid high for exactly 1 cycle, 2 cycles after the stop sample.
- Single-bit error: send 7'b1111010 (bit 5 flipped) → syn_in = 3'b101, data_out = 4'b1011, corr_flag = 1. With the macro enabled, err_count = 1.
- Framing and glitch:
  - Stop bit 0 → frame_err pulses once, data_valid stays 0.
  - 4-cycle low glitch on idle line → no state beyond START, busy returns to 0.
- Overrun: hold data_ready = 0 and send two clean frames → the first word is retained in data_out, overrun = 1 after the second DECODE. Then raise data_ready → one accept, data_valid = 0.
- Reset mid-frame: assert rst during DATA bit 3 → all outputs are 0 next cycle, and a following clean frame decodes correctly.
- Saturation (macro on): send 300 single-error frames → err_count = 8'hFF.

Source files
------------

// File: rtl/hamming_rx_ctrl.sv
// hamming_rx_ctrl: serial frame receiver that sequences an external Hamming decoder into a one-deep output buffer.
// Define HAMMING_RX_ERRCNT_EN to build the saturating corrected-frame counter on err_count.
module hamming_rx_ctrl #(
  parameter int N = 7,
  parameter int K = 4,
  parameter int C = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_in,
  output logic [N-1:0] code_word,
  output logic         code_valid,
  input  logic [C-1:0] syn_in,
  input  logic [K-1:0] corr_in,
  output logic [K-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         corr_flag,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy,
  output logic [7:0]   err_count
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0] code_q, code_d;
  logic [K-1:0] data_q, data_d;
  logic dv_q, dv_d, flag_q, flag_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_meta_q, rx_s_q, load;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      code_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      flag_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q <= rx_meta_q;
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      code_q <= code_d;
      data_q <= data_d;
      dv_q <= dv_d;
      flag_q <= flag_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d = idx_q;
    code_d = code_q;
    dv_d = dv_q && !data_ready;
    ferr_d = 1'b0;
    ovr_d = ovr_q;
    load = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (timer_q == HALF_END) begin
        timer_d = '0;
        idx_d = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (timer_q == BIT_END) begin
        timer_d = '0;
        code_d[idx_q] = rx_s_q;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? STOP : DATA;
      end
      STOP: if (timer_q == BIT_END) begin
        timer_d = '0;
        ferr_d = !rx_s_q;
        state_d = rx_s_q ? DECODE : IDLE;
      end
      DECODE: begin
        timer_d = '0;
        state_d = IDLE;
        load = !dv_q || data_ready;
        ovr_d = ovr_q || !load;
      end
      default: state_d = IDLE;
    endcase
    // A reload in DECODE wins over the accept-driven clear of data_valid
    data_d = load ? corr_in : data_q;
    flag_d = load ? |syn_in : flag_q;
    dv_d = load || dv_d;
  end
`ifdef HAMMING_RX_ERRCNT_EN
  logic [7:0] errc_q;
  always_ff @(posedge clk) begin
    if (rst) errc_q <= 8'h00;
    else if (load && |syn_in && errc_q != 8'hFF) errc_q <= errc_q + 8'h01;
  end
  assign err_count = errc_q;
`else
  assign err_count = 8'h00;
`endif
  assign code_word = code_q;
  assign code_valid = state_q == DECODE;
  assign data_out = data_q;
  assign data_valid = dv_q;
  assign corr_flag = flag_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign busy = state_q != IDLE;
endmodule
